// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the memory responder.
//   byte_t        - one storage byte
//   word_bytes_t  - four bytes, index 0 is the most significant
//   resp_state_t  - responder FSM states
package mem_pkg;

    localparam int DEF_LATENCY   = 4;
    localparam int DEF_ADDR_BITS = 16;

    typedef logic [7:0]   byte_t;
    typedef byte_t [0:3]  word_bytes_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    // Keep only byte 0 of a read word; the cache does any sign extension.
    function automatic word_bytes_t byte_lane0(input word_bytes_t w);
        word_bytes_t r;
        r    = '0;
        r[0] = w[0];
        return r;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// mem_byte_array: synchronous byte-addressed storage with a 4-byte port.
//   clk, rst_n  - clock, async active-low reset (read register only)
//   rd_en       - capture mem[base_addr+k] into rdata at this edge
//   wr_strb     - per-byte write strobes, index k writes mem[base_addr+k]
//   base_addr   - first byte address of the access
//   wdata       - write bytes, index 0 goes to base_addr
//   rdata       - registered read bytes, held until the next rd_en
module mem_byte_array
    import mem_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_en,
    input  logic [0:3]           wr_strb,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  word_bytes_t          wdata,
    output word_bytes_t          rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    // Storage is intentionally not reset.
    byte_t mem [0:DEPTH-1];

    logic [ADDR_BITS-1:0] lane_addr [0:3];
    word_bytes_t          rdata_d;
    word_bytes_t          rdata_q;

    // Per-lane addresses wrap naturally at the top of storage.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = base_addr + ADDR_BITS'(k);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_strb[k]) begin
                mem[lane_addr[k]] <= wdata[k];
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            for (int k = 0; k < 4; k++) begin
                rdata_d[k] = mem[lane_addr[k]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with fixed latency.
//   clk, reset   - clock, async active-low reset
//   req_valid    - request present (sampled only in IDLE)
//   req_ready    - responder is IDLE and will accept at the next edge
//   req_addr     - byte address; bits above ADDR_BITS alias
//   req_we       - 1 write, 0 read
//   req_is_word  - 1 four-byte access (aligned down), 0 single byte
//   req_wdata    - write bytes, index 0 = MSB
//   resp_valid   - one-cycle completion pulse
//   resp_rdata   - last read result, held until the next read completes
//   busy         - request in flight (BUSY or RESP)
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int LATENCY   = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic        req_is_word,
    input  word_bytes_t req_wdata,
    output logic        resp_valid,
    output word_bytes_t resp_rdata,
    output logic        busy
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_BITS-1:0] WORD_MASK = ~ADDR_BITS'(3);

    resp_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 we_q, we_d;
    logic                 word_q, word_d;
    word_bytes_t          wdata_q, wdata_d;
    logic                 ready_q, ready_d;
    logic                 rvalid_q, rvalid_d;
    logic                 busy_q, busy_d;
    // Shape of the most recent read; writes leave it (and the data) alone.
    logic                 rd_word_q, rd_word_d;

    logic                 access;
    logic [0:3]           wr_strb;
    logic                 rd_en;
    word_bytes_t          arr_rdata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        word_d    = word_q;
        wdata_d   = wdata_q;
        rd_word_d = rd_word_q;
        rvalid_d  = 1'b0;
        access    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    // Word accesses silently align down to a 4-byte boundary.
                    addr_d  = req_is_word ? (req_addr[ADDR_BITS-1:0] & WORD_MASK)
                                          : req_addr[ADDR_BITS-1:0];
                    we_d    = req_we;
                    word_d  = req_is_word;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    access   = 1'b1;
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                    if (!we_q) begin
                        rd_word_d = word_q;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // All FSM state and its outputs registered together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            word_q    <= 1'b0;
            wdata_q   <= '0;
            ready_q   <= 1'b1;
            rvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            rd_word_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            word_q    <= word_d;
            wdata_q   <= wdata_d;
            ready_q   <= ready_d;
            rvalid_q  <= rvalid_d;
            busy_q    <= busy_d;
            rd_word_q <= rd_word_d;
        end
    end

    // A byte write only touches lane 0 at the unaligned address.
    always_comb begin
        wr_strb = 4'b0000;
        if (access && we_q) begin
            wr_strb = word_q ? 4'b1111 : 4'b1000;
        end
    end

    assign rd_en = access && !we_q;

    mem_byte_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk       (clk),
        .rst_n     (reset),
        .rd_en     (rd_en),
        .wr_strb   (wr_strb),
        .base_addr (addr_q),
        .wdata     (wdata_q),
        .rdata     (arr_rdata)
    );

    always_comb begin
        resp_rdata = rd_word_q ? arr_rdata : byte_lane0(arr_rdata);
    end

    assign req_ready  = ready_q;
    assign resp_valid = rvalid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder at LATENCY=4 (dut a)
// and LATENCY=1 (dut b).
module tb_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        a_valid, a_ready, a_we, a_word, a_rvalid, a_busy;
    logic [31:0] a_addr;
    word_bytes_t a_wdata, a_rdata;

    logic        b_valid, b_ready, b_we, b_word, b_rvalid, b_busy;
    logic [31:0] b_addr;
    word_bytes_t b_wdata, b_rdata;

    int errors = 0;
    int checks = 0;

    mem_responder #(.ADDR_BITS(16), .LATENCY(4)) dut_a (
        .clk(clk), .reset(rst_n),
        .req_valid(a_valid), .req_ready(a_ready), .req_addr(a_addr),
        .req_we(a_we), .req_is_word(a_word), .req_wdata(a_wdata),
        .resp_valid(a_rvalid), .resp_rdata(a_rdata), .busy(a_busy)
    );

    mem_responder #(.ADDR_BITS(16), .LATENCY(1)) dut_b (
        .clk(clk), .reset(rst_n),
        .req_valid(b_valid), .req_ready(b_ready), .req_addr(b_addr),
        .req_we(b_we), .req_is_word(b_word), .req_wdata(b_wdata),
        .resp_valid(b_rvalid), .resp_rdata(b_rdata), .busy(b_busy)
    );

    // Issues one request, then scrambles the inputs while it is in flight.
    // lat = rising edges after the acceptance edge until resp_valid is seen
    // (LATENCY expected), or -1 if no response within the budget.
    task automatic do_req(input bit fast, input bit we, input bit word,
                          input logic [31:0] addr, input word_bytes_t wd,
                          output int lat, output word_bytes_t rd);
        @(negedge clk);
        if (fast) begin
            b_valid = 1'b1; b_we = we; b_word = word; b_addr = addr; b_wdata = wd;
        end else begin
            a_valid = 1'b1; a_we = we; a_word = word; a_addr = addr; a_wdata = wd;
        end
        @(posedge clk);
        @(negedge clk);
        if (fast) begin
            b_valid = 1'b0; b_we = ~we; b_word = ~word; b_addr = 32'hFFFF_FFFF; b_wdata = 32'h0BAD_F00D;
        end else begin
            a_valid = 1'b0; a_we = ~we; a_word = ~word; a_addr = 32'hFFFF_FFFF; a_wdata = 32'h0BAD_F00D;
        end
        lat = -1;
        rd  = '0;
        for (int n = 0; n < 20; n++) begin
            if (fast ? b_rvalid : a_rvalid) begin
                lat = n;
                rd  = fast ? b_rdata : a_rdata;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 0; a_we = 0; a_word = 0; a_addr = 0; a_wdata = 0;
        b_valid = 0; b_we = 0; b_word = 0; b_addr = 0; b_wdata = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_ready, a_rvalid, a_busy} !== 3'b100 || a_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_a: ready/rvalid/busy=%b rdata=%h, want 100 / 00000000",
                     {a_ready, a_rvalid, a_busy}, a_rdata);
        end
        checks++;
        if ({b_ready, b_rvalid, b_busy} !== 3'b100 || b_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_b: ready/rvalid/busy=%b rdata=%h, want 100 / 00000000",
                     {b_ready, b_rvalid, b_busy}, b_rdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        int lat; word_bytes_t rd;
        do_req(0, 1, 1, 32'h0000_0010, 32'hDEAD_BEEF, lat, rd);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL word_wr_lat: got %0d want 4", lat); end
        do_req(0, 0, 1, 32'h0000_0010, 32'h0, lat, rd);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL word_rd_lat: got %0d want 4", lat); end
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_rd: got %h want deadbeef", rd); end
    endtask

    task automatic test_byte();
        int lat; word_bytes_t rd;
        do_req(0, 1, 0, 32'h0000_0012, 32'h5A11_2233, lat, rd);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL byte_wr_holds_rdata: got %h want deadbeef", rd); end
        do_req(0, 0, 1, 32'h0000_0010, 32'h0, lat, rd);
        checks++;
        if (rd !== 32'hDEAD_5AEF) begin errors++; $display("FAIL byte_wr_merge: got %h want dead5aef", rd); end
        do_req(0, 0, 0, 32'h0000_0013, 32'h0, lat, rd);
        checks++;
        if (rd !== 32'hEF00_0000) begin errors++; $display("FAIL byte_rd: got %h want ef000000", rd); end
    endtask

    task automatic test_align();
        int lat; word_bytes_t rd;
        do_req(0, 0, 1, 32'h0000_0013, 32'h0, lat, rd);
        checks++;
        if (rd !== 32'hDEAD_5AEF) begin errors++; $display("FAIL misaligned_rd: got %h want dead5aef", rd); end
        do_req(0, 0, 1, 32'h0001_0010, 32'h0, lat, rd);
        checks++;
        if (rd !== 32'hDEAD_5AEF) begin errors++; $display("FAIL alias_rd: got %h want dead5aef", rd); end
    endtask

    // req_valid held high for two full request periods (12 cycles).
    task automatic test_handshake();
        int resps = 0;
        int bad = 0;
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b0; a_word = 1'b1; a_addr = 32'h10; a_wdata = 0;
        @(posedge clk);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (a_ready !== (j % 6 == 5) || a_rvalid !== (j % 6 == 4) || a_busy !== (j % 6 <= 4)) begin
                bad++;
                $display("FAIL handshake_seq: cycle %0d ready/rvalid/busy=%b", j,
                         {a_ready, a_rvalid, a_busy});
            end
            if (a_rvalid) begin
                resps++;
                checks++;
                if (a_rdata !== 32'hDEAD_5AEF) begin
                    errors++;
                    $display("FAIL handshake_rdata: got %h want dead5aef", a_rdata);
                end
            end
            if (j == 1) a_addr = 32'h40;
            if (j == 5) a_addr = 32'h10;
            if (j == 11) a_valid = 1'b0;
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (resps !== 2) begin errors++; $display("FAIL handshake_count: got %0d want 2", resps); end
    endtask

    task automatic test_reset_mid();
        int lat; word_bytes_t rd;
        int seen = 0;
        do_req(0, 1, 1, 32'h0000_0020, 32'hA1B2_C3D4, lat, rd);
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b1; a_word = 1'b1; a_addr = 32'h20; a_wdata = 32'h1122_3344;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_ready, a_rvalid, a_busy} !== 3'b100 || a_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_outs: ready/rvalid/busy=%b rdata=%h, want 100 / 00000000",
                     {a_ready, a_rvalid, a_busy}, a_rdata);
        end
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (j == 2) rst_n = 1'b1;
            if (a_rvalid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_resp: got %0d pulses want 0", seen); end
        do_req(0, 0, 1, 32'h0000_0020, 32'h0, lat, rd);
        checks++;
        if (rd !== 32'hA1B2_C3D4) begin errors++; $display("FAIL reset_mid_storage: got %h want a1b2c3d4", rd); end
    endtask

    task automatic test_latency1();
        int lat; word_bytes_t rd;
        do_req(1, 1, 1, 32'h0000_0040, 32'h0102_0304, lat, rd);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL lat1_wr_lat: got %0d want 1", lat); end
        do_req(1, 0, 1, 32'h0000_0040, 32'h0, lat, rd);
        checks++;
        if (lat !== 1 || rd !== 32'h0102_0304) begin
            errors++; $display("FAIL lat1_rd: lat %0d data %h want 1 01020304", lat, rd);
        end
        do_req(1, 1, 0, 32'h0000_0041, 32'hFFEE_DDCC, lat, rd);
        checks++;
        if (rd !== 32'h0102_0304) begin errors++; $display("FAIL lat1_wr_hold: got %h want 01020304", rd); end
        do_req(1, 0, 0, 32'h0000_0041, 32'h0, lat, rd);
        checks++;
        if (rd !== 32'hFF00_0000) begin errors++; $display("FAIL lat1_byte_rd: got %h want ff000000", rd); end
        do_req(1, 0, 1, 32'h0000_0042, 32'h0, lat, rd);
        checks++;
        if (rd !== 32'h01FF_0304) begin errors++; $display("FAIL lat1_word_rd: got %h want 01ff0304", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_align();
        test_handshake();
        test_reset_mid();
        test_latency1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
